// File: rtl/io_bridge_fta64.sv
// io_bridge_fta64 -- single-outstanding bridge from one FTA64 master to four
// address-decoded device slots.
//
// Ports
//   clk                 rising-edge clock
//   rst                 asynchronous, active-high reset
//   req                 upstream master request (cyc, we, cti, cid, tid, padr, dat)
//   resp                registered response back to the master
//   busy                high whenever the bridge cannot take a new request
//   dev_cs              one-hot device select, pulses for one cycle per transaction
//   dev_req             registered copy of the accepted request, broadcast to all slots
//   dev_resp0..3        per-slot device responses
//
// A request is latched in IDLE and decoded against four base/mask windows
// (the lowest slot wins on overlap). The selected slot sees dev_cs for one
// cycle. Writes that do not use ERC are posted and get no response. Reads and
// ERC writes wait for a matching ack from the selected slot, up to TIMEOUT
// cycles. After that wait they report an error.

package fta_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_FIXED   = 3'b001;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_ERC     = 3'b011;

  typedef struct packed {
    logic        cyc;
    logic        we;
    logic [2:0]  cti;
    logic [3:0]  cid;
    logic [7:0]  tid;
    logic [31:0] padr;
    logic [63:0] dat;
  } fta_cmd_request64_t;

  typedef struct packed {
    logic [3:0]  cid;
    logic [7:0]  tid;
    logic [3:0]  pri;
    logic        ack;
    logic        err;
    logic        rty;
    logic [31:0] adr;
    logic [63:0] dat;
  } fta_cmd_response64_t;

endpackage

module io_bridge_fta64
  import fta_pkg::*;
#(
  parameter logic [31:0] DEV0_BASE = 32'hFEE00000,
  parameter logic [31:0] DEV1_BASE = 32'hFEE10000,
  parameter logic [31:0] DEV2_BASE = 32'hFEE20000,
  parameter logic [31:0] DEV3_BASE = 32'hFEE30000,
  parameter logic [31:0] DEV_MASK  = 32'hFFFF0000,
  parameter int          TIMEOUT   = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  fta_cmd_request64_t  req,
  output fta_cmd_response64_t resp,
  output logic                busy,
  output logic [3:0]          dev_cs,
  output fta_cmd_request64_t  dev_req,
  input  fta_cmd_response64_t dev_resp0,
  input  fta_cmd_response64_t dev_resp1,
  input  fta_cmd_response64_t dev_resp2,
  input  fta_cmd_response64_t dev_resp3
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  fta_cmd_request64_t  dev_req_q, dev_req_d;
  fta_cmd_response64_t resp_q, resp_d;
  logic [3:0]          cs_q, cs_d;
  logic [1:0]          slot_q, slot_d;
  logic                hit_q, hit_d;
  logic [CW-1:0]       cnt_q, cnt_d;

  logic                dec_hit;
  logic [1:0]          dec_slot;
  fta_cmd_response64_t sel_resp;
  logic                ack_match;
  logic                rsp_expected;

  // Address decode of the incoming request. The if/else chain gives the
  // lowest-numbered slot priority when windows overlap.
  always_comb begin
    dec_hit  = 1'b0;
    dec_slot = 2'd0;
    if ((req.padr & DEV_MASK) == (DEV0_BASE & DEV_MASK)) begin
      dec_hit  = 1'b1;
      dec_slot = 2'd0;
    end else if ((req.padr & DEV_MASK) == (DEV1_BASE & DEV_MASK)) begin
      dec_hit  = 1'b1;
      dec_slot = 2'd1;
    end else if ((req.padr & DEV_MASK) == (DEV2_BASE & DEV_MASK)) begin
      dec_hit  = 1'b1;
      dec_slot = 2'd2;
    end else if ((req.padr & DEV_MASK) == (DEV3_BASE & DEV_MASK)) begin
      dec_hit  = 1'b1;
      dec_slot = 2'd3;
    end
  end

  // Only the selected slot's response is considered. Its ack counts only
  // when it carries the cid/tid of the outstanding request.
  always_comb begin
    sel_resp = dev_resp0;
    case (slot_q)
      2'd0: sel_resp = dev_resp0;
      2'd1: sel_resp = dev_resp1;
      2'd2: sel_resp = dev_resp2;
      default: sel_resp = dev_resp3;
    endcase
  end

  assign ack_match = sel_resp.ack && (sel_resp.cid == dev_req_q.cid) &&
                     (sel_resp.tid == dev_req_q.tid);

  // Plain writes are posted. Reads and ERC writes expect an answer.
  assign rsp_expected = !dev_req_q.we || (dev_req_q.cti == CTI_ERC);

  // Next-state and datapath control. resp_d defaults to zero, so a response
  // loaded on entry to RESP is presented for exactly one cycle.
  always_comb begin
    state_d   = state_q;
    dev_req_d = dev_req_q;
    cs_d      = 4'b0000;
    slot_d    = slot_q;
    hit_d     = hit_q;
    cnt_d     = cnt_q;
    resp_d    = '0;
    case (state_q)
      IDLE: begin
        if (req.cyc) begin
          dev_req_d = req;
          slot_d    = dec_slot;
          hit_d     = dec_hit;
          cs_d      = dec_hit ? (4'b0001 << dec_slot) : 4'b0000;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        if (!rsp_expected) begin
          state_d = IDLE;
        end else if (hit_q) begin
          cnt_d   = '0;
          state_d = WAIT;
        end else begin
          resp_d.cid = dev_req_q.cid;
          resp_d.tid = dev_req_q.tid;
          resp_d.adr = dev_req_q.padr;
          resp_d.pri = 4'd7;
          resp_d.err = 1'b1;
          state_d    = RESP;
        end
      end
      WAIT: begin
        cnt_d      = cnt_q + CW'(1);
        resp_d.cid = dev_req_q.cid;
        resp_d.tid = dev_req_q.tid;
        resp_d.adr = dev_req_q.padr;
        resp_d.pri = 4'd7;
        // A matching ack takes precedence over a timeout in the same cycle.
        if (ack_match) begin
          resp_d.ack = 1'b1;
          resp_d.dat = sel_resp.dat;
          state_d    = RESP;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          resp_d.err = 1'b1;
          state_d    = RESP;
        end else begin
          resp_d = '0;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously so a reset in the
  // middle of a transaction drops it without a response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      dev_req_q <= '0;
      resp_q    <= '0;
      cs_q      <= 4'b0000;
      slot_q    <= 2'd0;
      hit_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      dev_req_q <= dev_req_d;
      resp_q    <= resp_d;
      cs_q      <= cs_d;
      slot_q    <= slot_d;
      hit_q     <= hit_d;
      cnt_q     <= cnt_d;
    end
  end

  assign busy    = (state_q != IDLE);
  assign dev_cs  = cs_q;
  assign dev_req = dev_req_q;
  assign resp    = resp_q;

  // Device response fields the bridge does not act on.
  logic unused_resp_bits;
  assign unused_resp_bits = ^{dev_resp0.pri, dev_resp0.err, dev_resp0.rty, dev_resp0.adr,
                              dev_resp1.pri, dev_resp1.err, dev_resp1.rty, dev_resp1.adr,
                              dev_resp2.pri, dev_resp2.err, dev_resp2.rty, dev_resp2.adr,
                              dev_resp3.pri, dev_resp3.err, dev_resp3.rty, dev_resp3.adr};

endmodule

// File: tb/tb_io_bridge_fta64.sv
// Testbench for io_bridge_fta64. Directed transactions push their expected
// upstream response into a scoreboard queue. A monitor on the falling edge
// pops and compares each response the bridge presents. Any response the
// bench did not expect is reported as an error.
module tb_io_bridge_fta64;
  import fta_pkg::*;

  logic                clk;
  logic                rst;
  fta_cmd_request64_t  req;
  fta_cmd_response64_t resp;
  logic                busy;
  logic [3:0]          dev_cs;
  fta_cmd_request64_t  dev_req;
  fta_cmd_response64_t dev_resp0, dev_resp1, dev_resp2, dev_resp3;

  int checks = 0;
  int errors = 0;
  fta_cmd_response64_t sbQ[$];

  io_bridge_fta64 dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .resp      (resp),
    .busy      (busy),
    .dev_cs    (dev_cs),
    .dev_req   (dev_req),
    .dev_resp0 (dev_resp0),
    .dev_resp1 (dev_resp1),
    .dev_resp2 (dev_resp2),
    .dev_resp3 (dev_resp3)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic fta_cmd_response64_t mkResp(input logic ack, input logic err,
                                                 input logic [3:0] cid, input logic [7:0] tid,
                                                 input logic [31:0] adr, input logic [63:0] dat);
    fta_cmd_response64_t r;
    r     = '0;
    r.ack = ack;
    r.err = err;
    r.cid = cid;
    r.tid = tid;
    r.adr = adr;
    r.dat = dat;
    r.pri = 4'd7;
    return r;
  endfunction

  function automatic fta_cmd_request64_t mkReq(input logic we, input logic [2:0] cti,
                                               input logic [3:0] cid, input logic [7:0] tid,
                                               input logic [31:0] padr, input logic [63:0] dat);
    fta_cmd_request64_t r;
    r      = '0;
    r.cyc  = 1'b1;
    r.we   = we;
    r.cti  = cti;
    r.cid  = cid;
    r.tid  = tid;
    r.padr = padr;
    r.dat  = dat;
    return r;
  endfunction

  function automatic fta_cmd_response64_t devAck(input logic [3:0] cid, input logic [7:0] tid,
                                                 input logic [63:0] dat);
    fta_cmd_response64_t r;
    r     = '0;
    r.ack = 1'b1;
    r.cid = cid;
    r.tid = tid;
    r.dat = dat;
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Presented on a falling edge; the bridge latches it on the next rising edge.
  task automatic applyStimulus(input fta_cmd_request64_t r);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) begin
      checks++;
      errors++;
      $display("[TB] FAIL applyIdle: busy stuck at %b, expected 0", busy);
    end
    req = r;
    @(posedge clk);
    #1 req = '0;
  endtask

  task automatic waitIdle(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (busy !== 1'b0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s: busy stuck at %b, expected 0", name, busy);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin : monitor
    fta_cmd_response64_t exp;
    if (!rst && (resp.ack || resp.err)) begin
      checks++;
      if (sbQ.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpectedResp: got ack=%b err=%b cid=%h tid=%h, expected none",
                 resp.ack, resp.err, resp.cid, resp.tid);
      end else begin
        exp = sbQ.pop_front();
        if (resp !== exp) begin
          errors++;
          $display("[TB] FAIL respMatch: got ack=%b err=%b rty=%b pri=%h cid=%h tid=%h adr=%h dat=%h, expected ack=%b err=%b rty=%b pri=%h cid=%h tid=%h adr=%h dat=%h",
                   resp.ack, resp.err, resp.rty, resp.pri, resp.cid, resp.tid, resp.adr, resp.dat,
                   exp.ack, exp.err, exp.rty, exp.pri, exp.cid, exp.tid, exp.adr, exp.dat);
        end
      end
    end
  end

  initial begin
    int  toCycles;
    logic busyDropped;
    rst       = 1'b1;
    req       = '0;
    dev_resp0 = '0;
    dev_resp1 = '0;
    dev_resp2 = '0;
    dev_resp3 = '0;

    // Reset state
    repeat (2) @(negedge clk);
    checkOutput("rstBusy", 64'(busy), 64'd0);
    checkOutput("rstCs", 64'(dev_cs), 64'd0);
    checkOutput("rstDevReq", 64'(dev_req != '0), 64'd0);
    checkOutput("rstResp", 64'(resp != '0), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Read from slot 1, device acks one cycle after dev_cs
    $display("[TB] read slot 1");
    sbQ.push_back(mkResp(1'b1, 1'b0, 4'h3, 8'h11, 32'hFEE10008, 64'h5A));
    applyStimulus(mkReq(1'b0, CTI_CLASSIC, 4'h3, 8'h11, 32'hFEE10008, 64'h0));
    @(negedge clk);
    checkOutput("rdCs", 64'(dev_cs), 64'b0010);
    checkOutput("rdBusy", 64'(busy), 64'd1);
    @(negedge clk);
    checkOutput("rdCsOff", 64'(dev_cs), 64'd0);
    dev_resp1 = devAck(4'h3, 8'h11, 64'h5A);
    @(negedge clk);
    dev_resp1 = '0;
    checkOutput("rdLatency", 64'(resp.ack), 64'd1);
    @(negedge clk);
    checkOutput("rdAckOnce", 64'(resp.ack), 64'd0);
    checkOutput("rdIdle", 64'(busy), 64'd0);

    // Posted write to slot 0
    $display("[TB] posted write slot 0");
    applyStimulus(mkReq(1'b1, CTI_CLASSIC, 4'h4, 8'h12, 32'hFEE00000, 64'h81));
    @(negedge clk);
    checkOutput("pwCs", 64'(dev_cs), 64'b0001);
    checkOutput("pwDat", dev_req.dat, 64'h81);
    @(negedge clk);
    checkOutput("pwIdle", 64'(busy), 64'd0);
    checkOutput("pwCsOff", 64'(dev_cs), 64'd0);

    // Read to an undecoded address
    $display("[TB] undecoded read");
    sbQ.push_back(mkResp(1'b0, 1'b1, 4'h2, 8'h13, 32'h12340000, 64'h0));
    applyStimulus(mkReq(1'b0, CTI_CLASSIC, 4'h2, 8'h13, 32'h12340000, 64'h0));
    @(negedge clk);
    checkOutput("ndCs", 64'(dev_cs), 64'd0);
    waitIdle("ndIdle");

    // Read to a silent slot 2: error after the full timeout wait
    $display("[TB] timeout on slot 2");
    sbQ.push_back(mkResp(1'b0, 1'b1, 4'h1, 8'h14, 32'hFEE20000, 64'h0));
    applyStimulus(mkReq(1'b0, CTI_CLASSIC, 4'h1, 8'h14, 32'hFEE20000, 64'h0));
    toCycles    = 0;
    busyDropped = 1'b0;
    for (int n = 1; n <= 400; n++) begin
      @(negedge clk);
      if (resp.err === 1'b1) begin
        toCycles = n;
        break;
      end
      if (busy !== 1'b1) busyDropped = 1'b1;
    end
    checkOutput("toCycles", 64'(toCycles), 64'd257);
    checkOutput("toBusy", 64'(busyDropped), 64'd0);
    waitIdle("toIdle");

    // Wrong-tid and unselected acks are ignored, then the right ack completes
    $display("[TB] filtered acks on slot 2");
    sbQ.push_back(mkResp(1'b1, 1'b0, 4'h5, 8'h22, 32'hFEE20010, 64'h1234));
    applyStimulus(mkReq(1'b0, CTI_CLASSIC, 4'h5, 8'h22, 32'hFEE20010, 64'h0));
    @(negedge clk);
    checkOutput("flCs", 64'(dev_cs), 64'b0100);
    @(negedge clk);
    dev_resp3 = devAck(4'h5, 8'h99, 64'hDEAD);
    @(negedge clk);
    dev_resp3 = '0;
    dev_resp2 = devAck(4'h5, 8'h23, 64'hBEEF);
    @(negedge clk);
    dev_resp2 = '0;
    dev_resp3 = devAck(4'h5, 8'h22, 64'hF00D);
    @(negedge clk);
    dev_resp3 = '0;
    checkOutput("flBusy", 64'(busy), 64'd1);
    dev_resp2 = devAck(4'h5, 8'h22, 64'h1234);
    @(negedge clk);
    dev_resp2 = '0;
    waitIdle("flIdle");

    // ERC write to slot 3 expects a response
    $display("[TB] ERC write slot 3");
    sbQ.push_back(mkResp(1'b1, 1'b0, 4'h6, 8'h33, 32'hFEE30020, 64'h0));
    applyStimulus(mkReq(1'b1, CTI_ERC, 4'h6, 8'h33, 32'hFEE30020, 64'h55));
    @(negedge clk);
    checkOutput("ercCs", 64'(dev_cs), 64'b1000);
    @(negedge clk);
    dev_resp3 = devAck(4'h6, 8'h33, 64'h0);
    @(negedge clk);
    dev_resp3 = '0;
    waitIdle("ercIdle");

    // Reset pulse during WAIT abandons the transaction
    $display("[TB] reset during wait");
    applyStimulus(mkReq(1'b0, CTI_CLASSIC, 4'h1, 8'h07, 32'hFEE00004, 64'h0));
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("rwBusy", 64'(busy), 64'd0);
    checkOutput("rwCs", 64'(dev_cs), 64'd0);
    checkOutput("rwDevReq", 64'(dev_req != '0), 64'd0);
    checkOutput("rwResp", 64'(resp != '0), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    dev_resp0 = devAck(4'h1, 8'h07, 64'h77);
    repeat (3) @(negedge clk);
    dev_resp0 = '0;
    checkOutput("rwIdle", 64'(busy), 64'd0);

    // Next read after reset completes normally
    sbQ.push_back(mkResp(1'b1, 1'b0, 4'h2, 8'h44, 32'hFEE1FFF8, 64'hCAFE));
    applyStimulus(mkReq(1'b0, CTI_CLASSIC, 4'h2, 8'h44, 32'hFEE1FFF8, 64'h0));
    @(negedge clk);
    checkOutput("arCs", 64'(dev_cs), 64'b0010);
    @(negedge clk);
    dev_resp1 = devAck(4'h2, 8'h44, 64'hCAFE);
    @(negedge clk);
    dev_resp1 = '0;
    waitIdle("arIdle");

    repeat (3) @(negedge clk);
    checkOutput("sbEmpty", 64'(sbQ.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
